instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter INST_WIDTH, default 8, instruction word width (3-bit opcode, rs, rt, 3-bit imm).
REQ-003 Parameter FIFO_DEPTH, default 2, prefetch buffer entries, power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 sysclk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 imem_req  out  1  read request to instruction memory this cycle.
REQ-008 imem_addr  out  PC_WIDTH  read address, valid when imem_req=1.
REQ-009 imem_data  in  INST_WIDTH  read data, one cycle after request.
REQ-010 imem_valid  in  1  imem_data valid; asserted exactly one cycle after each imem_req.
REQ-011 redirect_valid  in  1  branch/jump redirect from execute.
REQ-012 redirect_pc  in  PC_WIDTH  redirect target.
REQ-013 inst_valid  out  1  inst_out/inst_pc hold a valid instruction for decode.
REQ-014 inst_ready  in  1  decode accepts instruction this cycle.
REQ-015 inst_out  out  INST_WIDTH  instruction at FIFO head.
REQ-016 inst_pc  out  PC_WIDTH  address of inst_out.

Function
REQ-017 States: RESET_S (one cycle after reset release, no request), RUN (issue when space), STALL (FIFO plus in-flight full), FLUSH (one cycle after redirect, squash in-flight response).
REQ-018 A request SHALL issue in RUN only when count + inflight < FIFO_DEPTH; fetch_pc then increments by 1 modulo 2^PC_WIDTH (0xFF wraps to 0x00).
REQ-019 Sustained throughput SHALL be one instruction per cycle when inst_ready stays high.
REQ-020 Each returned word SHALL be pushed with the PC of the request that produced it; FIFO order equals request order.
REQ-021 Transfer to decode occurs on inst_valid & inst_ready; inst_out/inst_pc SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-022 inst_valid SHALL equal (count != 0); no combinational path from imem_data to inst_out.
REQ-023 Push and pop in the same cycle on a full FIFO SHALL both succeed, count unchanged.
REQ-024 On redirect_valid: FIFO emptied, inst_valid=0 next cycle, fetch_pc <= redirect_pc, in-flight response discarded, state FLUSH; first request to redirect_pc issued the cycle after FLUSH.
REQ-025 Redirect concurrent with inst_ready pop SHALL take priority; popped entry counts as delivered, nothing else retained.
REQ-026 Redirect during FLUSH SHALL replace target; newest redirect_pc wins.
REQ-027 imem_valid without an outstanding request SHALL be ignored.

Reset
REQ-028 While reset=1: imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, count=0, inflight=0, fetch_pc=RESET_PC, state RESET_S.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight response, including one returning the cycle after reset.
REQ-030 First imem_req with imem_addr=RESET_PC SHALL occur the second cycle after reset deasserts.

Structure
REQ-031 PC_WIDTH, INST_WIDTH, opcode field positions and the state enumeration SHALL live in the shared cpu package used by decode and the datapath.
REQ-032 The prefetch buffer SHALL be a sub-module fetch_fifo (sync FIFO, push/pop/full/empty/count), instantiated once.
REQ-033 Output consumed directly by instructiondecode; fetch_fifo reset by the same reset.

Verification
REQ-034 Reset release, inst_ready=1, memory returns addr as data -> inst_out 0x00,0x01,0x02... one per cycle, first inst_valid third cycle after release.
REQ-035 inst_ready=0 for 5 cycles -> exactly FIFO_DEPTH requests issued, imem_req then 0, head stays 0x00/PC 0x00; ready=1 resumes in order, no loss or duplicate.
REQ-036 redirect_valid with redirect_pc=0x40 while response for 0x05 in flight -> 0x05 never delivered, next inst_pc=0x40.
REQ-037 Start at RESET_PC=0xFE, ready=1 -> inst_pc sequence 0xFE,0xFF,0x00,0x01.
REQ-038 Reset asserted mid-stream with full FIFO -> inst_valid=0 next cycle, stale response ignored, refetch from RESET_PC.
REQ-039 Redirects to 0x10 then 0x20 on consecutive cycles -> first delivered inst_pc=0x20.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions and
// the fetch-unit state enumeration used by fetch, decode and the datapath.
package instruction_fetch_pkg;

    localparam int CPU_PC_WIDTH   = 8;
    localparam int CPU_INST_WIDTH = 8;

    // Instruction word layout: [7:5] opcode, [4] rs, [3] rt, [2:0] imm
    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 5;
    localparam int RS_BIT     = 4;
    localparam int RT_BIT     = 3;
    localparam int IMM_MSB    = 2;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        RUN     = 2'd1,
        STALL   = 2'd2,
        FLUSH   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
        logic                           rs;
        logic                           rt;
        logic [IMM_MSB-IMM_LSB:0]       imm;
    } inst_fields_t;

    function automatic inst_fields_t split_inst(input logic [CPU_INST_WIDTH-1:0] word);
        inst_fields_t f;
        f.opcode = word[OPCODE_MSB:OPCODE_LSB];
        f.rs     = word[RS_BIT];
        f.rt     = word[RT_BIT];
        f.imm    = word[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous prefetch FIFO (module fetch_fifo): simultaneous push and pop
// are accepted even when full; flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential reads to a one-cycle instruction
// memory, buffers returned words with their PCs and hands them to decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = CPU_PC_WIDTH,
    parameter int                  INST_WIDTH = CPU_INST_WIDTH,
    parameter int                  FIFO_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  sysclk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  imem_valid,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [PC_WIDTH-1:0]   inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t                   state;
    fetch_state_t                   next_state;
    logic [PC_WIDTH-1:0]            fetch_pc;
    logic [PC_WIDTH-1:0]            inflight_pc;
    logic                           inflight;
    logic [CW-1:0]                  count;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [PC_WIDTH+INST_WIDTH-1:0] head;
    logic                           pop;
    logic                           push;
    logic                           issue;
    logic                           has_space;
    logic [CW:0]                    occupancy_next;

    // A pop this cycle frees a slot in time for the word requested now,
    // which is what sustains one instruction per cycle with a 2-deep buffer.
    assign pop       = !reset && !fifo_empty && inst_ready;
    assign has_space = ({1'b0, count} + (CW+1)'(inflight)) < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
    assign issue     = !reset && !redirect_valid && (state == RUN || state == STALL) && has_space;
    assign push      = imem_valid && inflight && (state != FLUSH) && !redirect_valid
                       && (!fifo_full || pop);

    assign occupancy_next = ({1'b0, count} + (CW+1)'(push) + (CW+1)'(issue)) - (CW+1)'(pop);

    fetch_fifo #(
        .WIDTH (PC_WIDTH + INST_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sysclk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= RESET_S;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    // A redirect always lands in FLUSH, so a second one simply retargets it.
    always_comb begin
        next_state = state;
        case (state)
            RESET_S: next_state = RUN;
            RUN,
            STALL:   next_state = (occupancy_next >= (CW+1)'(FIFO_DEPTH)) ? STALL : RUN;
            FLUSH:   next_state = RUN;
            default: next_state = RESET_S;
        endcase
        if (redirect_valid) begin
            next_state = FLUSH;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = issue ? fetch_pc : '0;
    assign inst_valid = !reset && !fifo_empty;
    assign inst_out   = inst_valid ? head[INST_WIDTH-1:0] : '0;
    assign inst_pc    = inst_valid ? head[PC_WIDTH+INST_WIDTH-1:INST_WIDTH] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory returns its address as
// data, and a delivery-order model tracks which PC decode must see next.
module tb_instruction_fetch;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       inst_ready = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       inject = 1'b0;

    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       imem_valid;
    logic       inst_valid;
    logic [7:0] inst_out;
    logic [7:0] inst_pc;
    logic       mem_valid = 1'b0;
    logic [7:0] mem_data  = 8'h00;

    logic       fe_req;
    logic [7:0] fe_addr;
    logic       fe_valid = 1'b0;
    logic [7:0] fe_data  = 8'h00;
    logic       fe_inst_valid;
    logic [7:0] fe_inst_out;
    logic [7:0] fe_inst_pc;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 sysclk = ~sysclk;

    instruction_fetch #(
        .PC_WIDTH   (8),
        .INST_WIDTH (8),
        .FIFO_DEPTH (2),
        .RESET_PC   (8'h00)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    instruction_fetch #(
        .PC_WIDTH   (8),
        .INST_WIDTH (8),
        .FIFO_DEPTH (2),
        .RESET_PC   (8'hFE)
    ) dut_fe (
        .sysclk         (sysclk),
        .reset          (reset),
        .imem_req       (fe_req),
        .imem_addr      (fe_addr),
        .imem_data      (fe_data),
        .imem_valid     (fe_valid),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .inst_valid     (fe_inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (fe_inst_out),
        .inst_pc        (fe_inst_pc)
    );

    // One-cycle memory whose contents equal their address; inject forces a
    // spurious response that no request asked for.
    always @(posedge sysclk) begin
        mem_valid <= imem_req;
        mem_data  <= imem_addr;
        fe_valid  <= fe_req;
        fe_data   <= fe_addr;
    end
    assign imem_valid = mem_valid | inject;
    assign imem_data  = inject ? 8'hAA : mem_data;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks_total++;
        $display("[TB] FAIL %s: no delivery within bound", name);
    endtask

    task automatic cycle();
        @(posedge sysclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge sysclk);
    endtask

    task automatic wait_delivery(input string name, input logic [7:0] expected);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sysclk);
            if (inst_valid && inst_ready) begin
                found = 1'b1;
            end else begin
                @(posedge sysclk);
                #1;
            end
        end
        if (found) begin
            check_output(name, {24'h0, inst_pc}, {24'h0, expected});
        end else begin
            report_timeout(name);
        end
    endtask

    // Delivery model: decode must see consecutive PCs starting from the reset
    // PC or from the newest redirect target, each word equal to its PC.
    logic [7:0] exp_pc = 8'h00;
    logic       prev_hold = 1'b0;
    logic       prev_redirect = 1'b0;
    logic [7:0] prev_pc = 8'h00;
    logic [7:0] prev_out = 8'h00;

    always @(negedge sysclk) begin
        if (reset) begin
            check_output("reset_outputs",
                         {6'h0, imem_req, imem_addr, inst_valid, inst_out, inst_pc}, 32'h0);
            exp_pc        = 8'h00;
            prev_hold     = 1'b0;
            prev_redirect = 1'b0;
        end else begin
            if (prev_hold) begin
                check_output("hold_stable", {15'h0, inst_valid, inst_pc, inst_out},
                             {15'h0, 1'b1, prev_pc, prev_out});
            end
            if (prev_redirect) begin
                check_output("redirect_clears_valid", {31'h0, inst_valid}, 32'h0);
            end
            if (inst_valid && inst_ready) begin
                check_output("delivered_pc", {24'h0, inst_pc}, {24'h0, exp_pc});
                check_output("delivered_word", {24'h0, inst_out}, {24'h0, exp_pc});
                exp_pc = exp_pc + 8'd1;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end
            prev_hold     = inst_valid && !inst_ready && !redirect_valid;
            prev_pc       = inst_pc;
            prev_out      = inst_out;
            prev_redirect = redirect_valid;
        end
    end

    initial begin : fe_watch
        logic [7:0] fe_exp [4];
        int got;
        fe_exp[0] = 8'hFE;
        fe_exp[1] = 8'hFF;
        fe_exp[2] = 8'h00;
        fe_exp[3] = 8'h01;
        got = 0;
        @(negedge reset);
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge sysclk);
            if (fe_inst_valid && inst_ready) begin
                check_output("fe_wrap_pc", {24'h0, fe_inst_pc}, {24'h0, fe_exp[got]});
                got++;
            end
        end
        if (got < 4) begin
            report_timeout("fe_wrap_sequence");
        end
    end

    initial begin : main
        int nreq;
        bit found;

        // Reset release, streaming with decode always ready
        repeat (3) cycle();
        reset = 1'b0;
        at_neg();
        check_output("reset_s_no_req", {31'h0, imem_req}, 32'h0);
        cycle();
        at_neg();
        check_output("first_req", {31'h0, imem_req}, 32'h1);
        check_output("first_addr", {24'h0, imem_addr}, 32'h0);
        cycle();
        at_neg();
        check_output("no_valid_yet", {31'h0, inst_valid}, 32'h0);
        check_output("second_addr", {24'h0, imem_addr}, 32'h1);
        cycle();
        at_neg();
        check_output("first_valid", {31'h0, inst_valid}, 32'h1);
        check_output("first_pc", {24'h0, inst_pc}, 32'h0);
        cycle();
        at_neg();
        check_output("second_pc", {24'h0, inst_pc}, 32'h1);
        cycle();
        at_neg();
        check_output("third_pc", {24'h0, inst_pc}, 32'h2);
        repeat (4) cycle();

        // Decode stalls right after reset: only FIFO_DEPTH requests go out
        reset      = 1'b1;
        inst_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        nreq  = 0;
        for (int i = 0; i < 7; i++) begin
            at_neg();
            if (imem_req) nreq++;
            cycle();
        end
        check_output("stall_req_count", nreq, 32'd2);
        at_neg();
        check_output("stall_head_pc", {24'h0, inst_pc}, 32'h0);
        check_output("stall_head_word", {24'h0, inst_out}, 32'h0);
        check_output("stall_no_req", {31'h0, imem_req}, 32'h0);
        cycle();
        inst_ready = 1'b1;

        // Redirect while the response for 0x05 is in flight
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            at_neg();
            if (imem_req && imem_addr == 8'h05) found = 1'b1;
            cycle();
        end
        if (!found) report_timeout("req_0x05");
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        cycle();
        redirect_valid = 1'b0;
        at_neg();
        check_output("flush_valid_low", {31'h0, inst_valid}, 32'h0);
        cycle();
        wait_delivery("redirect_target_pc", 8'h40);
        cycle();

        // Back-to-back redirects: the newest target wins
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        cycle();
        redirect_pc = 8'h20;
        cycle();
        redirect_valid = 1'b0;
        wait_delivery("double_redirect_pc", 8'h20);
        cycle();

        // Fetch PC wraps past 0xFF
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        cycle();
        redirect_valid = 1'b0;
        wait_delivery("wrap_first_pc", 8'hFE);
        cycle();
        repeat (6) cycle();

        // Reset with a full FIFO and a response in flight, then a stray response
        inst_ready = 1'b0;
        repeat (4) cycle();
        at_neg();
        check_output("full_before_reset", {31'h0, inst_valid}, 32'h1);
        cycle();
        inst_ready = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        reset  = 1'b0;
        inject = 1'b1;
        at_neg();
        check_output("valid_after_reset", {31'h0, inst_valid}, 32'h0);
        cycle();
        inject = 1'b0;
        wait_delivery("refetch_reset_pc", 8'h00);
        cycle();
        repeat (5) cycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
